map_sequencer: RTL and testbench
================================

# map_sequencer

Responder for the scoreboard's map-change handshake. It watches the scoreboard's `map_change` level and the packed two-bot `score` bus. On each change request it advances the active map, holds a fixed load window, and then returns a one-cycle `map_rst` to close the handshake. It also ends the match when either bot reaches the win score, and it sits between the scoreboard and the arena/map control logic.

## Interface
- `NUM_MAPS`, 4: number of arena maps; `map_sel` wraps modulo this value (must be ≥2).
- `MAP_W`, 2: width of `map_sel`; requires 2^MAP_W ≥ NUM_MAPS.
- `LOAD_CYCLES`, 8: cycles `map_loading` stays high before `map_rst` (must be ≥1).
- `RETRY_CYCLES`, 16: cycles spent in WAIT_CLR with `map_change` still high before `map_rst` is re-issued.
- `WIN_SCORE`, 8'd5: per-bot score that ends the match.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `board_rst`  in  1  synchronous, active-high reset.
- `map_change`  in  1  level from the scoreboard; high until it sees `map_rst`.
- `score`  in  16  [15:8] bot 1 score, [7:0] bot 2 score, unsigned.
- `map_sel`  out  MAP_W  index of the active map.
- `map_loading`  out  1  high during the load window.
- `map_rst`  out  1  one-cycle pulse to the scoreboard closing the handshake.
- `round`  out  8  count of completed map changes, saturates at 255.
- `game_over`  out  1  sticky match-end flag.
- `winner`  out  2  01 = bot 1, 10 = bot 2, 11 = tie, 00 = none.

## Operation
- All outputs are registered.
- Reset values: state IDLE, `map_sel` 0, `map_loading` 0, `map_rst` 0, `round` 0, `game_over` 0, `winner` 00, both counters 0.
- `board_rst` has highest priority in every state, including OVER.
- FSM states: IDLE, LOAD, PULSE, WAIT_CLR, OVER.

IDLE
- If `score[15:8]` ≥ WIN_SCORE or `score[7:0]` ≥ WIN_SCORE: go to OVER.
  - Set `game_over` = 1.
  - Set `winner` from the comparisons: both true → 11.
  - This check has priority over `map_change` in the same cycle, so no load starts.
- Else if `map_change` = 1: go to LOAD.
  - `map_sel` ← (`map_sel` = NUM_MAPS−1) ? 0 : `map_sel`+1.
  - Load counter ← LOAD_CYCLES−1.
  - `map_loading` ← 1.

LOAD
- Counter decrements each cycle.
- When the counter is 0: go to PULSE, with `map_loading` ← 0 and `map_rst` ← 1.

PULSE
- `map_rst` is high for this state only.
- Next state is WAIT_CLR, with `map_rst` ← 0.
- Retry counter ← 0.
- `round` increments, saturating at 255.

WAIT_CLR
- If `map_change` = 0: go to IDLE.
- Else the retry counter increments.
  - When it reaches RETRY_CYCLES−1: re-enter PULSE.
  - A retry re-pulses `map_rst` but does not advance `map_sel` and does not increment `round`.

OVER
- Terminal state; `map_change` is ignored.
- `map_rst` = 0 and `map_loading` = 0.
- Left only via `board_rst`.

Other rules
- `map_change` must be low in WAIT_CLR before a new request is accepted. A held-high level therefore never counts as two requests.
- Score comparisons are unsigned 8-bit; `score` is sampled only in IDLE.
- A score that reaches WIN_SCORE mid-transaction takes effect on the next IDLE cycle, after the current handshake closes.

## Timing
- `map_change` sampled high in IDLE at edge T:
  - `map_loading` is high for cycles T+1 … T+LOAD_CYCLES.
  - `map_rst` is high for exactly cycle T+LOAD_CYCLES+1.
  - `round` updates at T+LOAD_CYCLES+2.
- `map_sel` changes at T+1 and is stable through the whole load window.
- Minimum request-to-request spacing is LOAD_CYCLES+3 cycles: IDLE→LOAD, LOAD window, PULSE, WAIT_CLR with `map_change` already low, back to IDLE.
- Retry: with `map_change` held high, `map_rst` re-pulses every RETRY_CYCLES+1 cycles.
- Win score present in IDLE at edge T: `game_over` and `winner` are valid at T+1.
- `board_rst` asserted at edge T: all outputs hold reset values from T+1, whatever the state was. This includes mid-LOAD (`map_loading` drops) and mid-PULSE (`map_rst` drops).

## Test plan
- Reset, then one handshake:
  - Stimulus: hold `board_rst` 2 cycles; raise `map_change`; drop it 2 cycles after `map_rst`.
  - Response: `map_sel` 0→1; `map_loading` high 8 cycles; single `map_rst` pulse 9 cycles after the request; `round` = 1.
- Map wrap: 4 consecutive handshakes give `map_sel` 1, 2, 3, 0 and `round` = 4.
- Stuck request:
  - Stimulus: hold `map_change` high 40 cycles after the first `map_rst`.
  - Response: `map_rst` re-pulses every 17 cycles; `map_sel` and `round` unchanged.
- Win conditions:
  - `score` = 16'h0502 in IDLE → `game_over` = 1, `winner` = 01, later `map_change` ignored.
  - 16'h0505 → `winner` = 11.
  - 16'h0307 → `winner` = 10.
- Simultaneous request and win:
  - Stimulus: `map_change` = 1 with `score` = 16'h0005 on the same edge.
  - Response: OVER entered; no `map_loading` and no `map_rst`.
- Reset mid-load:
  - Stimulus: assert `board_rst` on the 4th LOAD cycle.
  - Response: next cycle all outputs are zero, `map_sel` = 0, no `map_rst` pulse is ever emitted.

Source files
------------

// File: rtl/map_sequencer.sv
// Map-change handshake responder: advances the arena map on each scoreboard request,
// holds a load window, closes the handshake with map_rst, and latches the match result.
module map_sequencer #(
    parameter int         NUM_MAPS     = 4,
    parameter int         MAP_W        = 2,
    parameter int         LOAD_CYCLES  = 8,
    parameter int         RETRY_CYCLES = 16,
    parameter logic [7:0] WIN_SCORE    = 8'd5
) (
    input  logic             clk,
    input  logic             board_rst,
    input  logic             map_change,
    input  logic [15:0]      score,
    output logic [MAP_W-1:0] map_sel,
    output logic             map_loading,
    output logic             map_rst,
    output logic [7:0]       round,
    output logic             game_over,
    output logic [1:0]       winner
);

    localparam int LOAD_W  = (LOAD_CYCLES  > 1) ? $clog2(LOAD_CYCLES)  : 1;
    localparam int RETRY_W = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;

    localparam logic [LOAD_W-1:0]  LOAD_INIT  = LOAD_W'(LOAD_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_CYCLES - 1);
    localparam logic [MAP_W-1:0]   LAST_MAP   = MAP_W'(NUM_MAPS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_PULSE    = 3'd2;
    localparam logic [2:0] S_WAIT_CLR = 3'd3;
    localparam logic [2:0] S_OVER     = 3'd4;

    logic [2:0]         state_q,       state_d;
    logic [MAP_W-1:0]   map_sel_q,     map_sel_d;
    logic               map_loading_q, map_loading_d;
    logic               map_rst_q,     map_rst_d;
    logic [7:0]         round_q,       round_d;
    logic               game_over_q,   game_over_d;
    logic [1:0]         winner_q,      winner_d;
    logic [LOAD_W-1:0]  load_cnt_q,    load_cnt_d;
    logic [RETRY_W-1:0] retry_cnt_q,   retry_cnt_d;
    logic               retry_pulse_q, retry_pulse_d;

    logic bot1_wins;
    logic bot2_wins;

    assign bot1_wins = (score[15:8] >= WIN_SCORE);
    assign bot2_wins = (score[7:0]  >= WIN_SCORE);

    always_comb begin
        state_d       = state_q;
        map_sel_d     = map_sel_q;
        map_loading_d = map_loading_q;
        map_rst_d     = map_rst_q;
        round_d       = round_q;
        game_over_d   = game_over_q;
        winner_d      = winner_q;
        load_cnt_d    = load_cnt_q;
        retry_cnt_d   = retry_cnt_q;
        retry_pulse_d = retry_pulse_q;

        case (state_q)
            S_IDLE: begin
                // A win outranks a pending request, so no load starts on the same edge
                if (bot1_wins || bot2_wins) begin
                    state_d     = S_OVER;
                    game_over_d = 1'b1;
                    winner_d    = {bot2_wins, bot1_wins};
                end else if (map_change) begin
                    state_d       = S_LOAD;
                    map_sel_d     = (map_sel_q == LAST_MAP) ? '0 : map_sel_q + MAP_W'(1);
                    load_cnt_d    = LOAD_INIT;
                    map_loading_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (load_cnt_q == '0) begin
                    state_d       = S_PULSE;
                    map_loading_d = 1'b0;
                    map_rst_d     = 1'b1;
                    retry_pulse_d = 1'b0;
                end else begin
                    load_cnt_d = load_cnt_q - LOAD_W'(1);
                end
            end
            S_PULSE: begin
                state_d     = S_WAIT_CLR;
                map_rst_d   = 1'b0;
                retry_cnt_d = '0;
                // Retries only re-close the handshake; they are not new map changes
                if (!retry_pulse_q && (round_q != 8'hFF)) begin
                    round_d = round_q + 8'd1;
                end
            end
            S_WAIT_CLR: begin
                if (!map_change) begin
                    state_d = S_IDLE;
                end else if (retry_cnt_q == RETRY_LAST) begin
                    state_d       = S_PULSE;
                    map_rst_d     = 1'b1;
                    retry_pulse_d = 1'b1;
                end else begin
                    retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                end
            end
            S_OVER: begin
                map_loading_d = 1'b0;
                map_rst_d     = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (board_rst) begin
            state_q       <= S_IDLE;
            map_sel_q     <= '0;
            map_loading_q <= 1'b0;
            map_rst_q     <= 1'b0;
            round_q       <= 8'd0;
            game_over_q   <= 1'b0;
            winner_q      <= 2'b00;
            load_cnt_q    <= '0;
            retry_cnt_q   <= '0;
            retry_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            map_sel_q     <= map_sel_d;
            map_loading_q <= map_loading_d;
            map_rst_q     <= map_rst_d;
            round_q       <= round_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
            load_cnt_q    <= load_cnt_d;
            retry_cnt_q   <= retry_cnt_d;
            retry_pulse_q <= retry_pulse_d;
        end
    end

    assign map_sel     = map_sel_q;
    assign map_loading = map_loading_q;
    assign map_rst     = map_rst_q;
    assign round       = round_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_map_sequencer.sv
// Directed bench for map_sequencer: handshakes are scored through an expectation queue,
// plus retry, win, simultaneous request/win and reset-during-load scenarios.
module tb_map_sequencer;

    logic        clk = 1'b0;
    logic        board_rst;
    logic        map_change;
    logic [15:0] score;
    logic [1:0]  map_sel;
    logic        map_loading;
    logic        map_rst;
    logic [7:0]  round;
    logic        game_over;
    logic [1:0]  winner;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] rnd;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    map_sequencer dut (
        .clk         (clk),
        .board_rst   (board_rst),
        .map_change  (map_change),
        .score       (score),
        .map_sel     (map_sel),
        .map_loading (map_loading),
        .map_rst     (map_rst),
        .round       (round),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic chg, input logic [15:0] sc);
        board_rst  = rst;
        map_change = chg;
        score      = sc;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_map_sel"},     32'(map_sel),     32'd0);
        checkOutput({tag, "_map_loading"}, 32'(map_loading), 32'd0);
        checkOutput({tag, "_map_rst"},     32'(map_rst),     32'd0);
        checkOutput({tag, "_round"},       32'(round),       32'd0);
        checkOutput({tag, "_game_over"},   32'(game_over),   32'd0);
        checkOutput({tag, "_winner"},      32'(winner),      32'd0);
    endtask

    task automatic do_reset(input string tag);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        step();
        step();
        check_reset_outputs(tag);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        step();
    endtask

    // Bounded wait for a map_rst pulse, reporting latency and load-window length
    task automatic wait_for_rst(output int lat, output int loads, output bit seen);
        lat   = 0;
        loads = 0;
        seen  = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            step();
            if (map_loading) loads++;
            if (map_rst) begin
                seen = 1'b1;
                lat  = i;
            end
        end
    endtask

    task automatic handshake(input logic [1:0] sel, input logic [7:0] rnd);
        int   lat;
        int   loads;
        bit   seen;
        exp_t e;
        applyStimulus(1'b0, 1'b1, 16'h0000);
        e.sel = sel;
        e.rnd = rnd;
        exp_q.push_back(e);
        wait_for_rst(lat, loads, seen);
        checkOutput("hs_rst_seen", 32'(seen), 32'd1);
        if (seen) begin
            e = exp_q.pop_front();
            checkOutput("hs_latency",     32'(lat),     32'd9);
            checkOutput("hs_loading_len", 32'(loads),   32'd8);
            checkOutput("hs_map_sel",     32'(map_sel), 32'(e.sel));
            step();
            checkOutput("hs_rst_single", 32'(map_rst), 32'd0);
            checkOutput("hs_round",      32'(round),   32'(e.rnd));
            step();
        end else begin
            exp_q.delete();
        end
        applyStimulus(1'b0, 1'b0, 16'h0000);
        step();
    endtask

    initial begin
        int   lat;
        int   loads;
        bit   seen;
        int   pulses;
        int   last;
        int   activity;
        exp_t e;

        applyStimulus(1'b1, 1'b0, 16'h0000);
        step();
        step();
        check_reset_outputs("reset");
        applyStimulus(1'b0, 1'b0, 16'h0000);
        step();

        handshake(2'd1, 8'd1);
        handshake(2'd2, 8'd2);
        handshake(2'd3, 8'd3);
        handshake(2'd0, 8'd4);

        // Stuck request: map_change never drops, map_rst must re-pulse every 17 cycles
        applyStimulus(1'b0, 1'b1, 16'h0000);
        e.sel = 2'd1;
        e.rnd = 8'd5;
        exp_q.push_back(e);
        wait_for_rst(lat, loads, seen);
        checkOutput("stuck_rst_seen", 32'(seen), 32'd1);
        if (seen) begin
            e = exp_q.pop_front();
            checkOutput("stuck_map_sel", 32'(map_sel), 32'(e.sel));
        end else begin
            exp_q.delete();
        end
        pulses = 0;
        last   = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (map_rst) begin
                pulses++;
                checkOutput("retry_spacing", 32'(i - last), 32'd17);
                last = i;
            end
        end
        checkOutput("retry_count",   32'(pulses),  32'd2);
        checkOutput("retry_map_sel", 32'(map_sel), 32'd1);
        checkOutput("retry_round",   32'(round),   32'd5);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        step();

        applyStimulus(1'b0, 1'b0, 16'h0502);
        step();
        checkOutput("win1_game_over", 32'(game_over), 32'd1);
        checkOutput("win1_winner",    32'(winner),    32'd1);
        applyStimulus(1'b0, 1'b1, 16'h0502);
        activity = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (map_loading || map_rst) activity++;
        end
        checkOutput("over_ignores_req", 32'(activity),  32'd0);
        checkOutput("over_map_sel",     32'(map_sel),   32'd1);
        checkOutput("over_round",       32'(round),     32'd5);
        checkOutput("over_sticky",      32'(game_over), 32'd1);
        do_reset("rst_after_win1");

        applyStimulus(1'b0, 1'b0, 16'h0505);
        step();
        checkOutput("tie_game_over", 32'(game_over), 32'd1);
        checkOutput("tie_winner",    32'(winner),    32'd3);
        do_reset("rst_after_tie");

        applyStimulus(1'b0, 1'b0, 16'h0307);
        step();
        checkOutput("win2_game_over", 32'(game_over), 32'd1);
        checkOutput("win2_winner",    32'(winner),    32'd2);
        do_reset("rst_after_win2");

        // Request and win on the same edge: the win must take priority
        applyStimulus(1'b0, 1'b1, 16'h0005);
        step();
        checkOutput("simul_game_over", 32'(game_over),   32'd1);
        checkOutput("simul_winner",    32'(winner),      32'd2);
        checkOutput("simul_loading",   32'(map_loading), 32'd0);
        checkOutput("simul_map_sel",   32'(map_sel),     32'd0);
        activity = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (map_loading || map_rst) activity++;
        end
        checkOutput("simul_no_activity", 32'(activity), 32'd0);
        do_reset("rst_after_simul");

        applyStimulus(1'b0, 1'b1, 16'h0000);
        step();
        checkOutput("midload_loading", 32'(map_loading), 32'd1);
        checkOutput("midload_map_sel", 32'(map_sel),     32'd1);
        step();
        step();
        applyStimulus(1'b1, 1'b1, 16'h0000);
        step();
        check_reset_outputs("midload_rst");
        applyStimulus(1'b0, 1'b0, 16'h0000);
        activity = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (map_rst || map_loading) activity++;
        end
        checkOutput("midload_no_pulse", 32'(activity), 32'd0);
        checkOutput("midload_round",    32'(round),    32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
